// File: rtl/edge_event_logger_pkg.sv
// Shared types for the multi-channel edge event logger.
// The event timestamp field exists only when EDGE_LOG_TS_EN is defined.
package edge_event_logger_pkg;

   // Event fields are sized for the largest supported build; the top slices them down.
   localparam int CHAN_W_MAX = 8;
   localparam int TS_W_MAX   = 32;

   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
`ifdef EDGE_LOG_TS_EN
      logic [TS_W_MAX-1:0]   ts;
`endif
      logic [CHAN_W_MAX-1:0] chan;
      logic                  rise;
   } evt_t;

endpackage

// File: rtl/edge_log_fifo.sv
// Synchronous event FIFO.
// Pointers carry one extra wrap bit to tell full from empty.
module edge_log_fifo
   import edge_event_logger_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic pop,
   input  evt_t din,
   output evt_t dout,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   evt_t        mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal when the head leaves on the same edge.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_ONE;
         if (do_pop)  rptr <= rptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/edge_event_logger.sv
// Multi-channel edge logger: sampler, per-channel pending slots, round-robin enqueue,
// saturating edge counters. Define EDGE_LOG_TS_EN to timestamp each event.
module edge_event_logger
   import edge_event_logger_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int DEPTH = 8,
   parameter int TS_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         sig_i,
   input  logic                   clear_i,
   output logic                   evt_valid_o,
   input  logic                   evt_ready_i,
   output logic [chan_w(NCH)-1:0] evt_chan_o,
   output logic                   evt_rise_o,
`ifdef EDGE_LOG_TS_EN
   output logic [TS_W-1:0]        evt_ts_o,
`endif
   output logic [NCH-1:0]         level_o,
   output logic [NCH*CNT_W-1:0]   edge_cnt_o,
   output logic                   overflow_o
);

   localparam int CW = chan_w(NCH);
   localparam logic [CW-1:0]    CH_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NCH-1:0]            edge_d;
   logic [NCH-1:0]            pend;
   logic [NCH-1:0]            pend_rise;
   logic [NCH-1:0]            gnt_oh;
   logic [NCH-1:0]            drop;
   logic [NCH-1:0][CNT_W-1:0] cnt;
   logic [CW-1:0]             rr_ptr;
   logic [CW-1:0]             gnt;
   logic                      gnt_vld;
   logic                      push;
   logic                      pop;
   logic                      fifo_full;
   logic                      fifo_empty;
   evt_t                      push_evt;
   evt_t                      head;
   logic                      unused_head;
`ifdef EDGE_LOG_TS_EN
   logic [TS_W-1:0]           ts_cnt;
   logic [NCH-1:0][TS_W-1:0]  pend_ts;
`else
   logic [TS_W-1:0]           unused_ts_w;
   assign unused_ts_w = '0;
`endif

   assign edge_d      = sig_i ^ level_o;
   assign pop         = evt_valid_o && evt_ready_i;
   assign push        = gnt_vld && (!fifo_full || pop);
   assign evt_valid_o = !fifo_empty;

   // Walk from the highest offset down so the channel nearest rr_ptr wins.
   always_comb begin : arbiter
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NCH) idx = idx - NCH;
         if (pend[idx]) begin
            gnt     = CW'(idx);
            gnt_vld = 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NCH; k++) gnt_oh[k] = push && (gnt == CW'(k));
      // A slot being granted this edge is free to take the new edge.
      drop          = edge_d & pend & ~gnt_oh;
      push_evt      = '0;
      push_evt.chan = CHAN_W_MAX'(gnt);
      push_evt.rise = pend_rise[gnt];
`ifdef EDGE_LOG_TS_EN
      push_evt.ts   = TS_W_MAX'(pend_ts[gnt]);
`endif
   end

   always_ff @(posedge clk) begin
      level_o <= sig_i;
      if (rst) begin
         pend       <= '0;
         pend_rise  <= '0;
         rr_ptr     <= '0;
         cnt        <= '0;
         overflow_o <= 1'b0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (edge_d[k] && !drop[k]) begin
               pend[k]      <= 1'b1;
               pend_rise[k] <= sig_i[k];
            end else if (gnt_oh[k]) begin
               pend[k] <= 1'b0;
            end
            if (clear_i)
               cnt[k] <= '0;
            else if (edge_d[k] && cnt[k] != CNT_MAX)
               cnt[k] <= cnt[k] + CNT_ONE;
         end
         if (push) rr_ptr <= (gnt == CW'(NCH - 1)) ? '0 : gnt + CH_ONE;
         overflow_o <= clear_i ? 1'b0 : (overflow_o | (|drop));
      end
   end

`ifdef EDGE_LOG_TS_EN
   always_ff @(posedge clk) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 1'b1;
      for (int k = 0; k < NCH; k++)
         if (!rst && edge_d[k] && !drop[k]) pend_ts[k] <= ts_cnt;
   end

   assign evt_ts_o    = head.ts[TS_W-1:0];
   assign unused_head = ^{head.chan, head.ts};
`else
   assign unused_head = ^head.chan;
`endif

   assign evt_chan_o = head.chan[CW-1:0];
   assign evt_rise_o = head.rise;
   assign edge_cnt_o = cnt;

   edge_log_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_evt),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_edge_event_logger.sv
// Directed bench for edge_event_logger (NCH=4, CNT_W=2, DEPTH=8, TS_W=4).
// Timestamp checks build only with EDGE_LOG_TS_EN defined.
module tb_edge_event_logger;

   localparam int NCH   = 4;
   localparam int CNT_W = 2;
   localparam int DEPTH = 8;
   localparam int TS_W  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   sig = '0;
   logic             clear = 1'b0;
   logic             ready = 1'b0;
   logic             evt_valid;
   logic [1:0]       evt_chan;
   logic             evt_rise;
   logic [NCH-1:0]   level;
   logic [NCH*CNT_W-1:0] edge_cnt;
   logic             overflow;
`ifdef EDGE_LOG_TS_EN
   logic [TS_W-1:0]  evt_ts;
`endif

   int checks   = 0;
   int failures = 0;
   logic [2:0] exp_q[$];

   edge_event_logger #(.NCH(NCH), .CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .sig_i       (sig),
      .clear_i     (clear),
      .evt_valid_o (evt_valid),
      .evt_ready_i (ready),
      .evt_chan_o  (evt_chan),
      .evt_rise_o  (evt_rise),
`ifdef EDGE_LOG_TS_EN
      .evt_ts_o    (evt_ts),
`endif
      .level_o     (level),
      .edge_cnt_o  (edge_cnt),
      .overflow_o  (overflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int k);
      return 32'(edge_cnt[k*CNT_W +: CNT_W]);
   endfunction

   // pop every queued event and compare against exp_q, then expect an empty FIFO
   task automatic drain(input string tag);
      logic [2:0] exp;
      ready = 1'b1;
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         check({tag, "_valid"}, 32'(evt_valid), 32'd1);
         check({tag, "_evt"}, 32'({evt_chan, evt_rise}), 32'(exp));
         tick();
      end
      check({tag, "_empty"}, 32'(evt_valid), 32'd0);
      ready = 1'b0;
   endtask

   initial begin
      // 1) single rising edge on ch0
      sig = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_cnt", 32'(edge_cnt), 32'h0);
      check("rst_ovf", 32'(overflow), 32'd0);
      sig = 4'b0001;
      tick();
      check("t1_level", 32'(level), 32'h1);
      check("t1_valid_early", 32'(evt_valid), 32'd0);
      check("t1_cnt0", cnt_of(0), 32'd1);
      tick();
      check("t1_valid", 32'(evt_valid), 32'd1);
      check("t1_evt", 32'({evt_chan, evt_rise}), 32'({2'd0, 1'b1}));
      ready = 1'b1;
      tick();
      check("t1_popped", 32'(evt_valid), 32'd0);
      ready = 1'b0;

      // 2) all channels rise together: round-robin order from ch0
      sig = '0;
      reset_dut();
      ready = 1'b1;
      sig = 4'b1111;
      tick();
      check("t2_valid_early", 32'(evt_valid), 32'd0);
      for (int i = 0; i < NCH; i++) begin
         tick();
         check("t2_valid", 32'(evt_valid), 32'd1);
         check("t2_evt", 32'({evt_chan, evt_rise}), 32'({i[1:0], 1'b1}));
         check("t2_cnt", cnt_of(i), 32'd1);
      end
      tick();
      check("t2_empty", 32'(evt_valid), 32'd0);
      ready = 1'b0;

      // 3) FIFO fills, one event waits in pending, the next edge overflows
      sig = '0;
      reset_dut();
      for (int e = 1; e <= 10; e++) begin
         sig[1] = ~sig[1];
         if (e <= 9) exp_q.push_back({2'd1, (e % 2 == 1)});
         tick();
         if (e < 10) tick();
         if (e == 9) check("t3_ovf_before", 32'(overflow), 32'd0);
      end
      check("t3_ovf", 32'(overflow), 32'd1);
      check("t3_cnt1_sat", cnt_of(1), 32'd3);
      check("t3_head_stable", 32'({evt_chan, evt_rise}), 32'({2'd1, 1'b1}));
      drain("t3");
      check("t3_ovf_sticky", 32'(overflow), 32'd1);

      // 4) counter saturation, then clear_i with a same-cycle edge
      sig = '0;
      reset_dut();
      for (int e = 1; e <= 5; e++) begin
         sig[2] = ~sig[2];
         exp_q.push_back({2'd2, (e % 2 == 1)});
         tick();
      end
      check("t4_cnt2_sat", cnt_of(2), 32'd3);
      check("t4_ovf", 32'(overflow), 32'd0);
      sig[2] = ~sig[2];
      clear = 1'b1;
      exp_q.push_back({2'd2, 1'b0});
      tick();
      clear = 1'b0;
      check("t4_cnt2_clr", cnt_of(2), 32'd0);
      check("t4_ovf_clr", 32'(overflow), 32'd0);
      tick();
      drain("t4");

      // 5) reset with 3 events queued and 1 pending
      sig = '0;
      reset_dut();
      sig = 4'b0111;
      tick();
      sig = 4'b1111;
      tick();
      tick();
      tick();
      check("t5_valid_before", 32'(evt_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_valid", 32'(evt_valid), 32'd0);
      check("t5_cnt", 32'(edge_cnt), 32'h0);
      check("t5_level", 32'(level), 32'hf);
      tick();
      tick();
      check("t5_no_evt", 32'(evt_valid), 32'd0);

`ifdef EDGE_LOG_TS_EN
      // 6) timestamps at posedge 4 and 20 after reset: 3, then 19 wrapped to 3
      sig = '0;
      reset_dut();
      ready = 1'b1;
      for (int j = 1; j <= 22; j++) begin
         sig[3] = (j >= 4 && j < 20);
         tick();
         if (j == 5) begin
            check("t6_valid1", 32'(evt_valid), 32'd1);
            check("t6_ts1", 32'(evt_ts), 32'd3);
            check("t6_rise1", 32'(evt_rise), 32'd1);
         end
         if (j == 21) begin
            check("t6_valid2", 32'(evt_valid), 32'd1);
            check("t6_ts2", 32'(evt_ts), 32'd3);
            check("t6_rise2", 32'(evt_rise), 32'd0);
         end
      end
      ready = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
